// File: rtl/hex_digit_accumulator_if.sv
// Digit-entry / word-handoff bundle for hex_digit_accumulator.
// The par signal exists only when HEXACC_PARITY_EN is defined.
interface hex_digit_accumulator_if #(
  parameter int DIGITS = 4,
  parameter int SELW   = 2
);
  logic [3:0]          d;
  logic                sh;
  logic                wr;
  logic [SELW-1:0]     sel;
  logic                sclr;
  logic [4*DIGITS-1:0] q;
  logic [SELW:0]       cnt;
  logic                q_vld;
  logic                q_rdy;
  logic                ovf;
`ifdef HEXACC_PARITY_EN
  logic                par;
`endif

  // Producer/consumer side: keypad decoder plus HEX2BIN converter.
  modport master (
    output d, sh, wr, sel, sclr, q_rdy,
    input  q, cnt, q_vld, ovf
`ifdef HEXACC_PARITY_EN
    , input par
`endif
  );

  modport slave (
    input  d, sh, wr, sel, sclr, q_rdy,
    output q, cnt, q_vld, ovf
`ifdef HEXACC_PARITY_EN
    , output par
`endif
  );
endinterface

// File: rtl/hex_digit_accumulator.sv
// Collects DIGITS hex digits by shift-in or addressed write and hands the word on via valid/ready.
// Optional HEXACC_PARITY_EN adds a registered even-parity output of Q.
module hex_digit_accumulator #(
  parameter int DIGITS = 4,
  parameter int SELW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  hex_digit_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [SELW:0] CNT_FULL = (SELW+1)'(DIGITS);

  function automatic logic f_even_parity(input logic [4*DIGITS-1:0] v);
    return ^v;
  endfunction

  state_t              r_state, w_state_n;
  logic [4*DIGITS-1:0] r_q, w_q_n;
  logic [SELW:0]       r_cnt, w_cnt_n;
  logic                r_q_vld, w_q_vld_n;
  logic                r_ovf, w_ovf_n;
  logic                w_take;
  logic                w_sh_acc;

  assign w_take   = r_q_vld & bus.q_rdy;
  // A shift in HOLD is only accepted when the word is being taken on the same edge.
  assign w_sh_acc = bus.sh & ((r_state != ST_HOLD) | w_take);

  // Next-state and next-output computation.
  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_cnt_n   = r_cnt;
    w_q_vld_n = r_q_vld;
    w_ovf_n   = r_ovf;
    if (bus.sclr) begin
      w_state_n = ST_EMPTY;
      w_q_n     = {(4*DIGITS){1'b0}};
      w_cnt_n   = {(SELW+1){1'b0}};
      w_q_vld_n = 1'b0;
      w_ovf_n   = 1'b0;
    end else begin
      if (w_take) begin
        w_state_n = ST_EMPTY;
        w_cnt_n   = {(SELW+1){1'b0}};
        w_q_vld_n = 1'b0;
      end else begin
        w_state_n = r_state;
      end
      if (w_sh_acc) begin
        w_q_n   = {r_q[4*DIGITS-5:0], bus.d};
        w_cnt_n = w_cnt_n + {{SELW{1'b0}}, 1'b1};
        if (w_cnt_n == CNT_FULL) begin
          w_state_n = ST_HOLD;
          w_q_vld_n = 1'b1;
        end else begin
          w_state_n = ST_FILL;
        end
      end else begin
        if (bus.sh) begin
          w_ovf_n = 1'b1;
        end else begin
          w_ovf_n = r_ovf;
        end
        // Slots at or beyond DIGITS never match, so such writes fall away silently.
        for (int i = 0; i < DIGITS; i++) begin
          if (bus.wr && (bus.sel == SELW'(i))) begin
            w_q_n[4*i +: 4] = bus.d;
          end else begin
            w_q_n[4*i +: 4] = w_q_n[4*i +: 4];
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= ST_EMPTY;
      r_q     <= {(4*DIGITS){1'b0}};
      r_cnt   <= {(SELW+1){1'b0}};
      r_q_vld <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_cnt   <= w_cnt_n;
      r_q_vld <= w_q_vld_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign bus.q     = r_q;
  assign bus.cnt   = r_cnt;
  assign bus.q_vld = r_q_vld;
  assign bus.ovf   = r_ovf;

`ifdef HEXACC_PARITY_EN
  logic r_par;

  // Parity register, loaded from the same next-Q so it always tracks Q.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_par <= 1'b0;
    end else begin
      r_par <= f_even_parity(w_q_n);
    end
  end

  assign bus.par = r_par;
`endif

endmodule
